// File: rtl/hazard_stall_ctl.sv
// Load-use stall and branch flush sequencer between IF/ID and ID/EX.
// Optional STALL_PERF_EN macro adds saturating stall/flush cycle counters.
module hazard_stall_ctl #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic [1:0] hz_state
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_e;

  localparam logic [3:0] SC1 = 4'(STALL_CYCLES - 1);
  localparam logic [3:0] FC1 = 4'(FLUSH_CYCLES - 1);

  hz_e        state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       hazard;
  logic       in_stall, in_flush;
  logic       last;

  assign hazard = idex_memread & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) |
                   (ifid_uses_rt & (idex_rt == ifid_rt)));

  // any encoding other than STALL/FLUSH behaves as RUN
  assign in_stall = (state == STALL);
  assign in_flush = (state == FLUSH);
  assign last     = (cnt <= 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    state_nx    = RUN;
    cnt_nx      = 4'd0;
    hz_state    = RUN;
    if (in_flush) hz_state = FLUSH;
    else if (in_stall) hz_state = STALL;

    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nx = FLUSH;
        cnt_nx   = FC1;
      end
    end else if (in_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      cnt_nx      = cnt - 4'd1;
      state_nx    = last ? RUN : FLUSH;
    end else if (in_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cnt_nx      = cnt - 4'd1;
      state_nx    = last ? RUN : STALL;
    end else if (hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nx = STALL;
        cnt_nx   = SC1;
      end
    end

    // reset forces a safe frozen/flushed pipeline front end
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      hz_state    = RUN;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!pc_write && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Scoreboard bench for hazard_stall_ctl: two configurations
// (3/2 and 1/1 cycles) against a remaining-cycle reference model.
module tb_hazard_stall_ctl;

  typedef struct packed {
    logic [5:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mr = 1'b0, ur = 1'b0, bt = 1'b0;
  logic [4:0] irt = '0, rs = '0, rt = '0;

  logic       pcw3, ifw3, bub3, fl3;
  logic [1:0] hz3;
  logic       pcw1, ifw1, bub1, fl1;
  logic [1:0] hz1;
  logic [31:0] sc3, fc3, sc1, fc1;

  exp_t q3[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int sl3 = 0, fl3m = 0, sl1 = 0, fl1m = 0;
  int ps3 = 0, pf3 = 0, ps1 = 0, pf1 = 0;

  always #5 clk = ~clk;

  hazard_stall_ctl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut3 (
    .clk(clk), .reset(reset),
    .idex_memread(mr), .idex_rt(irt),
    .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(ur), .branch_taken(bt),
    .pc_write(pcw3), .ifid_write(ifw3),
    .idex_bubble(bub3), .ifid_flush(fl3),
    .hz_state(hz3)
`ifdef STALL_PERF_EN
    , .stall_cnt(sc3), .flush_cnt(fc3)
`endif
  );

  hazard_stall_ctl #(.STALL_CYCLES(1), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .idex_memread(mr), .idex_rt(irt),
    .ifid_rs(rs), .ifid_rt(rt),
    .ifid_uses_rt(ur), .branch_taken(bt),
    .pc_write(pcw1), .ifid_write(ifw1),
    .idex_bubble(bub1), .ifid_flush(fl1),
    .hz_state(hz1)
`ifdef STALL_PERF_EN
    , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
  );

`ifndef STALL_PERF_EN
  assign sc3 = '0;
  assign fc3 = '0;
  assign sc1 = '0;
  assign fc1 = '0;
`endif

  // sl/fl = cycles of stall/flush still owed after the current one
  task automatic model(input int s, input int f, input logic rst,
                       input logic hz, input logic b,
                       inout int sl, inout int fl,
                       inout int ps, inout int pf, output exp_t e);
    logic [1:0] st;
    logic [3:0] ctl;
    e.sc = 32'(ps);
    e.fc = 32'(pf);
    if (!rst) begin
      sl = 0; fl = 0; ps = 0; pf = 0;
      e.o = 6'b0011_00;
      e.sc = 32'(0);
      e.fc = 32'(0);
      return;
    end
    st = (fl > 0) ? 2'b10 : (sl > 0) ? 2'b01 : 2'b00;
    if (b) begin
      ctl = 4'b1111; fl = f - 1; sl = 0;
    end else if (fl > 0) begin
      ctl = 4'b1111; fl--;
    end else if (sl > 0) begin
      ctl = 4'b0010; sl--;
    end else if (hz) begin
      ctl = 4'b0010; sl = s - 1;
    end else begin
      ctl = 4'b1100;
    end
    e.o = {ctl, st};
    if (!ctl[3]) ps++;
    if (ctl[0]) pf++;
  endtask

  task automatic drv(input logic r, input logic m, input int a,
                     input int s1, input int t1, input logic u,
                     input logic b);
    exp_t e;
    logic hz;
    @(posedge clk);
    #1;
    reset = r; mr = m; irt = 5'(a); rs = 5'(s1); rt = 5'(t1);
    ur = u; bt = b;
    cyc++;
    hz = m && (a != 0) && ((a == s1) || (u && a == t1));
    model(3, 2, r, hz, b, sl3, fl3m, ps3, pf3, e);
    q3.push_back(e);
    model(1, 1, r, hz, b, sl1, fl1m, ps1, pf1, e);
    q1.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [5:0] got,
                     input logic [31:0] gs, input logic [31:0] gf,
                     input exp_t e);
    n_cmp++;
    if (got !== e.o) begin
      n_bad++;
      $display("FAIL %s cyc=%0d pcw/ifw/bub/fl/st got=%b exp=%b",
               nm, cyc, got, e.o);
    end
`ifdef STALL_PERF_EN
    n_cmp++;
    if (gs !== e.sc || gf !== e.fc) begin
      n_bad++;
      $display("FAIL %s_perf cyc=%0d got=%0d/%0d exp=%0d/%0d",
               nm, cyc, gs, gf, e.sc, e.fc);
    end
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      chk("s3f2", {pcw3, ifw3, bub3, fl3, hz3}, sc3, fc3, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("s1f1", {pcw1, ifw1, bub1, fl1, hz1}, sc1, fc1, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) drv(0, 0, 0, 0, 0, 0, 0);
    repeat (2) drv(1, 0, 0, 0, 0, 0, 0);
    // load-use on rs, then bubble in ID/EX
    drv(1, 1, 5, 5, 0, 0, 0);
    repeat (3) drv(1, 0, 5, 5, 0, 0, 0);
    // rt gating and rt==0
    drv(1, 1, 7, 1, 7, 0, 0);
    drv(1, 1, 7, 1, 7, 1, 0);
    repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    // branch aborts stall
    drv(1, 1, 9, 9, 0, 0, 0);
    drv(1, 1, 9, 9, 0, 0, 1);
    repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
    // hazard + branch together
    drv(1, 1, 3, 3, 3, 1, 1);
    repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
    // reset mid-flush
    drv(1, 0, 0, 0, 0, 0, 1);
    drv(0, 1, 4, 4, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 2, 2, 2, 1, 0);
    repeat (4) drv(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drv(($urandom_range(0, 63) != 0),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (q3.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d exp=0/0", q3.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
